vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/VESA raster timing generator; successor to the fixed 1024x768 generator.
//  Produces h/v sync of selectable polarity, an active-video flag, pixel/line coordinates, and
//  line_start/frame_start strobes; supports a pixel-clock divider and a run/stop control.
//  Sits between the system clock and the framebuffer address generator / DAC output stage.
// PARAMETERS
//  CW       11    counter and coordinate width (bits); must hold H_TOTAL-1 and V_TOTAL-1
//  H_VIS    1024  visible pixels per line
//  H_FP     24    horizontal front porch (pixels)
//  H_SYNC   136   horizontal sync width (pixels)
//  H_BP     160   horizontal back porch (pixels)
//  V_VIS    768   visible lines per frame
//  V_FP     3     vertical front porch (lines)
//  V_SYNC   6     vertical sync width (lines)
//  V_BP     29    vertical back porch (lines)
//  H_POL    0     h_sync active level (0 = active-low)
//  V_POL    0     v_sync active level (0 = active-low)
//  PIX_DIV  1     clk cycles per pixel (1..16)
// PORTS
//  clk          in   1   system clock; all state on posedge
//  rst          in   1   reset, asynchronous, active-high
//  run          in   1   1 = generate timing; 0 = hold counters at 0, outputs at reset values
//  h_sync       out  1   horizontal sync, level per H_POL
//  v_sync       out  1   vertical sync, level per V_POL
//  avr          out  1   active video region (h and v both visible)
//  vblank       out  1   line counter outside visible lines
//  pixel_num    out  CW  horizontal count aligned with avr (0..H_TOTAL-1)
//  line_num     out  CW  vertical count aligned with avr (0..V_TOTAL-1)
//  line_start   out  1   one-pixel strobe at pixel 0 of every line
//  frame_start  out  1   one-pixel strobe at pixel 0, line 0
//  pix_ce       out  1   pixel-enable strobe, 1 of every PIX_DIV clks
// BEHAVIOUR
//  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: visible, FP, sync, BP.
//  - Reset (async assert, sync release): h_cnt = v_cnt = div_cnt = 0; avr = vblank = 0;
//    h_sync = !H_POL; v_sync = !V_POL; pixel_num = line_num = 0; strobes = 0; pix_ce = 0.
//  - Divider: div_cnt counts 0..PIX_DIV-1 while run = 1; pix_ce = 1 in the cycle where
//    div_cnt = 0. With PIX_DIV = 1, pix_ce is constantly 1 while running.
//  - Counters advance only on pix_ce. h_cnt wraps at H_TOTAL-1 -> 0.
//    v_cnt increments on h wrap, and wraps at V_TOTAL-1 -> 0 on the same pix_ce.
//  - Decode is combinational from (h_cnt, v_cnt); all outputs are registered.
//    Latency is exactly 1 clk from the counter value; outputs change only in the clk after pix_ce.
//  - h_sync is active for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC; v_sync is the same in v_cnt
//    and changes with h_cnt = 0 of the line.
//  - avr = (h_cnt < H_VIS) && (v_cnt < V_VIS). vblank = (v_cnt >= V_VIS).
//  - line_start = (h_cnt == 0); frame_start = (h_cnt == 0 && v_cnt == 0).
//    Each strobe is held for one pixel period (PIX_DIV clks).
//  - run falling: on the next clk the counters clear to 0 and the outputs take reset values.
//    run rising: counting starts at (0,0); frame_start is asserted 1 clk after the first pix_ce.
//  - Reset mid-frame: immediate asynchronous return to reset values; no partial-frame recovery.
// STRUCTURE
//  - vga_timing_defs.vh: timing sets (VGA_1024x768_60, VGA_640x480_60) as localparam groups
//    and polarity constants; shared with the address generator.
//  - Sub-module vga_axis_counter (params VIS/FP/SYNC/BP/CW; in ce, clr; out cnt, wrap, sync, vis),
//    instantiated twice: horizontal with ce = pix_ce, vertical with ce = pix_ce & h wrap.
// TESTING
//  1 Defaults, rst then run = 1 -> first h_sync low at clk 1+1048; h_sync low for 136 clks;
//    line period 1344 clks.
//  2 Defaults -> frame_start period 1344*806 = 1083264 clks; v_sync low for 6 lines,
//    starting at the line where line_num = 771.
//  3 Defaults -> per line, avr high for exactly 1024 clks (pixel_num 0..1023); avr 0 for
//    every line_num in 768..805.
//  4 H_POL = 1, V_POL = 1, PIX_DIV = 2, 640x480 set -> h_sync high for 192 clks;
//    line period 1600 clks; pix_ce alternates.
//  5 Drop run at line 100, pixel 500 for 10 clks, then raise it -> outputs reset 1 clk after
//    the drop; restart has frame_start 1 clk after the first pix_ce.
//  6 Assert rst asynchronously mid-sync -> h_sync/v_sync go inactive with no clk edge;
//    the sequence after release is identical to scenario 1.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing sets and polarity constants for the VGA timing generator
// and the framebuffer address generator.
package vga_timing_gen_pkg;

   localparam int POL_NEG = 0;
   localparam int POL_POS = 1;

   // 1024x768 @ 60 Hz, 65 MHz pixel clock
   localparam int VGA1024_H_VIS  = 1024;
   localparam int VGA1024_H_FP   = 24;
   localparam int VGA1024_H_SYNC = 136;
   localparam int VGA1024_H_BP   = 160;
   localparam int VGA1024_V_VIS  = 768;
   localparam int VGA1024_V_FP   = 3;
   localparam int VGA1024_V_SYNC = 6;
   localparam int VGA1024_V_BP   = 29;
   localparam int VGA1024_H_POL  = POL_NEG;
   localparam int VGA1024_V_POL  = POL_NEG;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int VGA640_H_VIS   = 640;
   localparam int VGA640_H_FP    = 16;
   localparam int VGA640_H_SYNC  = 96;
   localparam int VGA640_H_BP    = 48;
   localparam int VGA640_V_VIS   = 480;
   localparam int VGA640_V_FP    = 10;
   localparam int VGA640_V_SYNC  = 2;
   localparam int VGA640_V_BP    = 33;
   localparam int VGA640_H_POL   = POL_NEG;
   localparam int VGA640_V_POL   = POL_NEG;

   function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: counter over visible/front-porch/sync/back-porch with wrap,
// sync-region and visible-region decode.
module vga_axis_counter
   import vga_timing_gen_pkg::*;
#(
   parameter int VIS  = 1024,
   parameter int FP   = 24,
   parameter int SYNC = 136,
   parameter int BP   = 160,
   parameter int CW   = 11
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ce_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          wrap_o,
   output logic          sync_o,
   output logic          vis_o
);

   localparam int TOTAL = axis_total(VIS, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
   localparam logic [CW-1:0] VIS_END   = CW'(VIS);
   localparam logic [CW-1:0] SYNC_BEG  = CW'(VIS + FP);
   localparam logic [CW-1:0] SYNC_LAST = CW'(VIS + FP + SYNC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ce_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = (cnt_q == LAST);
   assign sync_o = (cnt_q >= SYNC_BEG) && (cnt_q <= SYNC_LAST);
   assign vis_o  = (cnt_q < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator with pixel-clock divider and
// run/stop control; all raster outputs registered one clk after the counters.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int CW      = 11,
   parameter int H_VIS   = VGA1024_H_VIS,
   parameter int H_FP    = VGA1024_H_FP,
   parameter int H_SYNC  = VGA1024_H_SYNC,
   parameter int H_BP    = VGA1024_H_BP,
   parameter int V_VIS   = VGA1024_V_VIS,
   parameter int V_FP    = VGA1024_V_FP,
   parameter int V_SYNC  = VGA1024_V_SYNC,
   parameter int V_BP    = VGA1024_V_BP,
   parameter int H_POL   = VGA1024_H_POL,
   parameter int V_POL   = VGA1024_V_POL,
   parameter int PIX_DIV = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic          h_sync,
   output logic          v_sync,
   output logic          avr,
   output logic          vblank,
   output logic [CW-1:0] pixel_num,
   output logic [CW-1:0] line_num,
   output logic          line_start,
   output logic          frame_start,
   output logic          pix_ce
);

   localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
   localparam logic       HS_IDLE  = (H_POL == 0);
   localparam logic       VS_IDLE  = (V_POL == 0);

   logic [3:0]    div_cnt_q, div_cnt_d;
   logic          ce;
   logic [CW-1:0] h_cnt, v_cnt;
   logic          h_wrap, v_wrap_unused;
   logic          h_sact, v_sact, h_vis, v_vis;

   logic          h_sync_q, v_sync_q, avr_q, vblank_q, line_start_q, frame_start_q;
   logic          h_sync_d, v_sync_d, avr_d, vblank_d, line_start_d, frame_start_d;
   logic [CW-1:0] pixel_num_q, line_num_q, pixel_num_d, line_num_d;

   // Pixel enable is held low while in reset so it reads 0 alongside the other outputs.
   assign ce = run & ~rst & (div_cnt_q == '0);

   always_comb begin
      div_cnt_d = div_cnt_q + 4'd1;
      if (!run || (div_cnt_q == DIV_LAST)) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   vga_axis_counter #(
      .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
   ) u_h_axis (
      .clk_i(clk), .rst_i(rst), .ce_i(ce), .clr_i(~run),
      .cnt_o(h_cnt), .wrap_o(h_wrap), .sync_o(h_sact), .vis_o(h_vis)
   );

   vga_axis_counter #(
      .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
   ) u_v_axis (
      .clk_i(clk), .rst_i(rst), .ce_i(ce & h_wrap), .clr_i(~run),
      .cnt_o(v_cnt), .wrap_o(v_wrap_unused), .sync_o(v_sact), .vis_o(v_vis)
   );

   always_comb begin
      h_sync_d      = (H_POL != 0) ? h_sact : ~h_sact;
      v_sync_d      = (V_POL != 0) ? v_sact : ~v_sact;
      avr_d         = h_vis & v_vis;
      vblank_d      = ~v_vis;
      pixel_num_d   = h_cnt;
      line_num_d    = v_cnt;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
   end

   // Outputs load only on pixel enable, so every strobe lasts one full pixel period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_sync_q      <= HS_IDLE;
         v_sync_q      <= VS_IDLE;
         avr_q         <= 1'b0;
         vblank_q      <= 1'b0;
         pixel_num_q   <= '0;
         line_num_q    <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (!run) begin
         h_sync_q      <= HS_IDLE;
         v_sync_q      <= VS_IDLE;
         avr_q         <= 1'b0;
         vblank_q      <= 1'b0;
         pixel_num_q   <= '0;
         line_num_q    <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (ce) begin
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         avr_q         <= avr_d;
         vblank_q      <= vblank_d;
         pixel_num_q   <= pixel_num_d;
         line_num_q    <= line_num_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign avr         = avr_q;
   assign vblank      = vblank_q;
   assign pixel_num   = pixel_num_q;
   assign line_num    = line_num_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign pix_ce      = ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized run/stop and async-reset stimulus on a small raster, checked every
// clk against a pixel-index reference model.
module tb_vga_timing_gen;

   localparam int CW  = 6;
   localparam int HV  = 10, HF = 2, HS = 3, HB = 4;
   localparam int VV  = 6,  VF = 1, VS = 2, VB = 2;
   localparam int HP  = 1,  VP = 0;
   localparam int DIV = 3;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic          h_sync, v_sync, avr, vblank, line_start, frame_start, pix_ce;
   logic [CW-1:0] pixel_num, line_num;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state: clocks spent running since the last start, and the pixel index shown.
   int m_edges = 0;
   int m_p     = 0;
   bit m_valid = 1'b0;

   vga_timing_gen #(
      .CW(CW), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(HP), .V_POL(VP), .PIX_DIV(DIV)
   ) dut (
      .clk(clk), .rst(rst), .run(run),
      .h_sync(h_sync), .v_sync(v_sync), .avr(avr), .vblank(vblank),
      .pixel_num(pixel_num), .line_num(line_num),
      .line_start(line_start), .frame_start(frame_start), .pix_ce(pix_ce)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edges = 0;
         m_valid = 1'b0;
         m_p     = 0;
      end else if (run) begin
         m_p     = m_edges / DIV;
         m_valid = 1'b1;
         m_edges = m_edges + 1;
      end else begin
         m_edges = 0;
         m_valid = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string ph);
      int  h, v;
      bit  hact, vact;
      logic e_hs, e_vs, e_avr, e_vb, e_ls, e_fs, e_ce;
      int  e_px, e_ln;
      h    = m_p % HT;
      v    = (m_p / HT) % VT;
      hact = (h >= HV + HF) && (h < HV + HF + HS);
      vact = (v >= VV + VF) && (v < VV + VF + VS);
      if (m_valid) begin
         e_hs  = (HP == 1) ? hact : !hact;
         e_vs  = (VP == 1) ? vact : !vact;
         e_avr = (h < HV) && (v < VV);
         e_vb  = (v >= VV);
         e_px  = h;
         e_ln  = v;
         e_ls  = (h == 0);
         e_fs  = (h == 0) && (v == 0);
      end else begin
         e_hs  = (HP == 0);
         e_vs  = (VP == 0);
         e_avr = 1'b0;
         e_vb  = 1'b0;
         e_px  = 0;
         e_ln  = 0;
         e_ls  = 1'b0;
         e_fs  = 1'b0;
      end
      e_ce = run && !rst && ((m_edges % DIV) == 0);
      chk({ph, ".h_sync"},      32'(h_sync),      32'(e_hs));
      chk({ph, ".v_sync"},      32'(v_sync),      32'(e_vs));
      chk({ph, ".avr"},         32'(avr),         32'(e_avr));
      chk({ph, ".vblank"},      32'(vblank),      32'(e_vb));
      chk({ph, ".pixel_num"},   32'(pixel_num),   32'(e_px));
      chk({ph, ".line_num"},    32'(line_num),    32'(e_ln));
      chk({ph, ".line_start"},  32'(line_start),  32'(e_ls));
      chk({ph, ".frame_start"}, 32'(frame_start), 32'(e_fs));
      chk({ph, ".pix_ce"},      32'(pix_ce),      32'(e_ce));
   endtask

   task automatic cycles(input string ph, input int n);
      repeat (n) begin
         @(negedge clk);
         check_all(ph);
      end
   endtask

   initial begin
      bit found;

      cycles("reset", 3);
      rst = 1'b0;
      cycles("idle", 3);

      // Two full frames of continuous running from (0,0).
      run = 1'b1;
      cycles("frame", 2 * HT * VT * DIV + 20);

      // Stop mid-frame for 10 clks, then restart.
      found = 1'b0;
      for (int i = 0; i < 2 * HT * VT * DIV && !found; i++) begin
         @(negedge clk);
         check_all("seek");
         if (pixel_num == CW'(5) && line_num == CW'(4)) found = 1'b1;
      end
      chk("seek_found", 32'(found), 32'd1);
      run = 1'b0;
      cycles("stopped", 10);
      run = 1'b1;
      cycles("restart", HT * DIV * 3);

      // Random run/stop toggling.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         check_all("rnd");
         if ($urandom_range(0, 99) < 2) run = ~run;
      end

      // Async reset while both syncs are active.
      run   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 3 * HT * VT * DIV && !found; i++) begin
         @(negedge clk);
         check_all("seek_sync");
         if (h_sync == 1'b1 && v_sync == 1'b0) found = 1'b1;
      end
      chk("sync_found", 32'(found), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all("arst");
      @(negedge clk);
      check_all("arst_hold");
      rst = 1'b0;
      cycles("after_rst", HT * VT * DIV + 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
